// File: rtl/top_level_if.sv
// Start/Ack handshake between a sequencer host and the multiply controller.
interface top_level_if;
  logic start;
  logic ack;

  modport master (output start, input  ack);
  modport slave  (input  start, output ack);
endinterface

// File: rtl/top_level.sv
// Memory-to-memory 16x16 shift-and-add multiplier: operands from DM1.Core[1..4], product to Core[5..8].
// Define TOP_LEVEL_SIGNED_MUL_EN for a two's-complement product; the default build is unsigned.

module top_level_dm #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  // No reset: contents survive rst_n so a host can preload and inspect them.
  logic [7:0] Core [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) Core[addr] <= wdata;
  end

  assign rdata = Core[addr];
endmodule

module top_level_rf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          acc_we,
  input  logic [31:0]   acc_wdata,
  output logic [15:0]   op_a,
  output logic [15:0]   op_b,
  output logic [31:0]   acc_q
);
  // Map: [0..1] operand A, [2..3] operand B, [4..7] product accumulator (MSB byte first).
  logic [7:0] Registers [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) Registers[waddr] <= wdata;
    if (acc_we) begin
      Registers[4] <= acc_wdata[31:24];
      Registers[5] <= acc_wdata[23:16];
      Registers[6] <= acc_wdata[15:8];
      Registers[7] <= acc_wdata[7:0];
    end
  end

  assign op_a  = {Registers[0], Registers[1]};
  assign op_b  = {Registers[2], Registers[3]};
  assign acc_q = {Registers[4], Registers[5], Registers[6], Registers[7]};
endmodule

// state | meaning
// IDLE  | waiting for a sampled start 1 -> 0 transition
// LOAD  | copy Core[1..4] into Registers[0..3], one byte per cycle
// MUL   | 16 shift-and-add steps, LSB of B first, product in Registers[4..7]
// STORE | copy Registers[4..7] to Core[5..8], one byte per cycle
// DONE  | result in memory; ack high until start returns high
module top_level #(
  parameter int DM_DEPTH = 256,
  parameter int RF_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  top_level_if.slave  bus
);
  localparam int DM_AW = $clog2(DM_DEPTH);
  localparam int RF_AW = $clog2(RF_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         tmr_q, tmr_d;
  logic               start_q;
  logic               ack_q, ack_d;

  logic               dm_we;
  logic [DM_AW-1:0]   dm_addr;
  logic [7:0]         dm_wdata, dm_rdata;
  logic               rf_we;
  logic [RF_AW-1:0]   rf_waddr;
  logic               acc_we;
  logic [31:0]        acc_wdata, acc_q;
  logic [15:0]        op_a, op_b;

  logic [1:0]         byte_idx;
  logic [3:0]         bit_idx;
  logic [31:0]        a_ext, addend, acc_base, mul_sum;

  top_level_dm #(.DEPTH(DM_DEPTH), .AW(DM_AW)) DM1 (
    .clk   (clk),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  top_level_rf #(.DEPTH(RF_DEPTH), .AW(RF_AW)) RF1 (
    .clk       (clk),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (dm_rdata),
    .acc_we    (acc_we),
    .acc_wdata (acc_wdata),
    .op_a      (op_a),
    .op_b      (op_b),
    .acc_q     (acc_q)
  );

  // The down-counter runs 3..0 or 15..0, so its complement is the ascending step index.
  assign byte_idx = ~tmr_q[1:0];
  assign bit_idx  = ~tmr_q;
  assign dm_wdata = acc_q[{tmr_q[1:0], 3'b000} +: 8];

`ifdef TOP_LEVEL_SIGNED_MUL_EN
  assign a_ext = {{16{op_a[15]}}, op_a};
`else
  assign a_ext = {16'h0000, op_a};
`endif

  // First MUL step starts from zero instead of whatever the accumulator held.
  assign acc_base = (tmr_q == 4'd15) ? 32'h0000_0000 : acc_q;

  always_comb begin
    addend = op_b[bit_idx] ? (a_ext << bit_idx) : 32'h0000_0000;
`ifdef TOP_LEVEL_SIGNED_MUL_EN
    // B's MSB carries negative weight in two's complement.
    if (bit_idx == 4'd15) mul_sum = acc_base - addend;
    else                  mul_sum = acc_base + addend;
`else
    mul_sum = acc_base + addend;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= 4'd0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      start_q <= bus.start;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ack_d     = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    rf_we     = 1'b0;
    rf_waddr  = RF_AW'(byte_idx);
    acc_we    = 1'b0;
    acc_wdata = mul_sum;

    case (state_q)
      IDLE: begin
        if (!bus.start && start_q) begin
          state_d = LOAD;
          tmr_d   = 4'd3;
        end
      end
      LOAD: begin
        dm_addr = DM_AW'(32'd1 + 32'(byte_idx));
        if (bus.start) begin
          state_d = IDLE;
          tmr_d   = 4'd0;
        end else begin
          rf_we = 1'b1;
          if (tmr_q == 4'd0) begin
            state_d = MUL;
            tmr_d   = 4'd15;
          end else begin
            tmr_d = tmr_q - 4'd1;
          end
        end
      end
      MUL: begin
        if (bus.start) begin
          state_d = IDLE;
          tmr_d   = 4'd0;
        end else begin
          acc_we = 1'b1;
          if (tmr_q == 4'd0) begin
            state_d = STORE;
            tmr_d   = 4'd3;
          end else begin
            tmr_d = tmr_q - 4'd1;
          end
        end
      end
      STORE: begin
        dm_addr = DM_AW'(32'd5 + 32'(byte_idx));
        if (bus.start) begin
          state_d = IDLE;
          tmr_d   = 4'd0;
        end else begin
          dm_we = 1'b1;
          if (tmr_q == 4'd0) state_d = DONE;
          else               tmr_d   = tmr_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.start) state_d = IDLE;
        else           ack_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = 4'd0;
      end
    endcase
  end

  assign bus.ack = ack_q;
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: preloads operands hierarchically, scoreboards expected products.
module tb_top_level;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  top_level_if bus ();

  top_level #(.DM_DEPTH(256), .RF_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef TOP_LEVEL_SIGNED_MUL_EN
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
`else
    return {16'h0000, a} * {16'h0000, b};
`endif
  endfunction

  function automatic logic [31:0] result();
    return {dut.DM1.Core[5], dut.DM1.Core[6], dut.DM1.Core[7], dut.DM1.Core[8]};
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dut.DM1.Core[0] = 8'h5A;
    dut.DM1.Core[1] = a[15:8];
    dut.DM1.Core[2] = a[7:0];
    dut.DM1.Core[3] = b[15:8];
    dut.DM1.Core[4] = b[7:0];
    dut.DM1.Core[9] = 8'hA5;
  endtask

  // Returns just after the posedge that leaves IDLE.
  task automatic launch();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
  endtask

  task automatic complete(input string tag);
    int n;
    int bad;
    logic got;
    logic [31:0] exp;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      got = bus.ack;
    end
    chk({tag, " latency"}, n, 32'd25);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, " product"}, result(), exp);
    chk({tag, " guard bytes"}, {dut.DM1.Core[0], dut.DM1.Core[9]}, 16'h5AA5);
    bad = 0;
    for (int i = 8; i < 16; i++)
      if (dut.RF1.Registers[i] !== 8'(8'hC0 + i)) bad++;
    chk({tag, " upper regs"}, bad, 0);
  endtask

  task automatic release_ack(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " ack drop"}, bus.ack, 1'b0);
  endtask

  task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b);
    preload(a, b);
    sb_q.push_back(model(a, b));
    launch();
    complete(tag);
    release_ack(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    logic [7:0]  core_snap [0:15];
    logic [7:0]  rf_snap [0:15];
    int          seen;
    int          diff;
    logic [15:0] ra, rb;

    bus.start = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("reset ack", bus.ack, 1'b0);
    chk("reset counter", dut.tmr_q, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 8; i < 16; i++) dut.RF1.Registers[i] = 8'(8'hC0 + i);

    run_check("vec_03ff_fffb", 16'h03FF, 16'hFFFB);

    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.ack) seen++;
    end
    chk("held start idle ack", seen, 0);
    chk("held start product", result(), model(16'h03FF, 16'hFFFB));

    run_check("max_operands", 16'hFFFF, 16'hFFFF);
    run_check("zero_a", 16'h0000, 16'h1234);
    run_check("zero_b", 16'hABCD, 16'h0000);
    run_check("mixed", 16'h1234, 16'h5678);
    run_check("msb_only", 16'h8000, 16'h8000);
    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_check($sformatf("random%0d", k), ra, rb);
    end

    // Abort during the eighth MUL cycle.
    prev = result();
    preload(16'h0102, 16'h0304);
    launch();
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.ack) seen++;
    end
    chk("abort ack", seen, 0);
    chk("abort product kept", result(), prev);
    chk("abort counter idle", dut.tmr_q, 4'd0);
    sb_q.push_back(model(16'h0102, 16'h0304));
    launch();
    complete("after_abort");
    release_ack("after_abort");

    // Reset pulse mid-MUL.
    prev = result();
    preload(16'h00FF, 16'h0101);
    launch();
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      core_snap[i] = dut.DM1.Core[i];
      rf_snap[i]   = dut.RF1.Registers[i];
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun reset ack", bus.ack, 1'b0);
    chk("midrun reset counter", dut.tmr_q, 4'd0);
    diff = 0;
    for (int i = 0; i < 16; i++) begin
      if (dut.DM1.Core[i] !== core_snap[i]) diff++;
      if (dut.RF1.Registers[i] !== rf_snap[i]) diff++;
    end
    chk("midrun reset retains memories", diff, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.ack) seen++;
    end
    chk("post reset stays idle", seen, 0);
    chk("post reset product kept", result(), prev);
    sb_q.push_back(model(16'h00FF, 16'h0101));
    launch();
    complete("after_reset");

    // Reset while DONE drops ack without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("done reset ack", bus.ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    chk("scoreboard drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
